// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and
// synchronous flush. Depth need not be a power of two.
//
// Build option:
//   FIFO_FWFT_EN  defined   -> first-word fall-through; rd_data shows the head
//                              entry combinationally while empty=0, rd_en pops.
//                 undefined -> registered read; rd_data valid the cycle after
//                              an accepted rd_en and held until the next one.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               sync clear of contents (highest priority)
//   wr_en, wr_data      write request / word
//   rd_en, rd_data      read request (pop) / word
//   full, empty         count == data_depth / count == 0
//   almost_full         count >= af_level
//   almost_empty        count <= ae_level
//   count               occupancy, addr_width+1 bits
//   overflow, underflow sticky drop flags, cleared by clr_err or reset
//   clr_err             sync clear of overflow/underflow
module sync_fifo_flags #(
  parameter int data_width = 8,
  parameter int data_depth = 16,
  parameter int addr_width = 4,
  parameter int af_level   = 14,
  parameter int ae_level   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [data_width-1:0] wr_data,
  input  logic                  rd_en,
  output logic [data_width-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam logic [addr_width-1:0] LAST  = addr_width'(data_depth - 1);
  localparam logic [addr_width:0]   DEPTH = (addr_width+1)'(data_depth);
  localparam logic [addr_width:0]   AF    = (addr_width+1)'(af_level);
  localparam logic [addr_width:0]   AE    = (addr_width+1)'(ae_level);

  logic [data_width-1:0] mem [data_depth];
  logic [addr_width-1:0] wr_ptr, rd_ptr;
  logic [addr_width:0]   count_nxt;
  logic                  wr_acc, rd_acc, ovf_evt, unf_evt;

  always_comb begin
    // A read frees a slot in the same cycle, so a full FIFO still takes a
    // write when a read is accepted alongside it. Flush suppresses both.
    rd_acc  = rd_en & ~empty & ~flush;
    wr_acc  = wr_en & (~full | rd_acc) & ~flush;
    ovf_evt = wr_en & ~wr_acc & ~flush;
    unf_evt = rd_en & empty & ~flush;
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end
  end

  // Storage carries no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        // Wrap at data_depth-1 so non-power-of-2 depths work.
        if (wr_acc) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        if (rd_acc) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF);
      almost_empty <= (count_nxt <= AE);
      // A new error in the same cycle wins over clr_err.
      if (ovf_evt)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (unf_evt)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head entry is always on the output; meaningless while empty.
  assign rd_data = mem[rd_ptr];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rd_data <= '0;
    else if (rd_acc) rd_data <= mem[rd_ptr];
  end
`endif

endmodule
